// File: rtl/lc_sweep_pkg.sv
// lc_sweep_pkg: shared types and helpers for the logic-circuit sweep engine.
//   state_t    - sweep FSM state encoding
//   DEF_POLY   - default MISR feedback polynomial (CRC-16/CCITT taps)
//   misr_step  - one MISR shift/fold step, width-generic up to 32 bits
package lc_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;

    // Computes the next signature on a 32-bit container; bits above w are
    // masked so callers may truncate the result to their own width.
    function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                              input logic [31:0] din,
                                              input logic [31:0] poly,
                                              input int unsigned w);
        logic [31:0] mask;
        logic        msb;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        msb  = sig[5'(w - 1)];
        return ((sig << 1) ^ (msb ? poly : 32'd0) ^ din) & mask;
    endfunction

endpackage

// File: rtl/lc_sweep_engine_if.sv
// lc_sweep_engine_if: stimulus/response pair channel from the sweep engine
// to a downstream logger.
//   out_valid - pair available (master drives)
//   out_ready - logger accepts pair (slave drives)
//   out_stim  - stimulus code of the pair
//   out_resp  - captured response of the pair
interface lc_sweep_engine_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 5
);
    logic             out_valid;
    logic             out_ready;
    logic [N_IN-1:0]  out_stim;
    logic [N_OUT-1:0] out_resp;

    modport master (output out_valid, output out_stim, output out_resp, input out_ready);
    modport slave  (input out_valid, input out_stim, input out_resp, output out_ready);
endinterface

// File: rtl/lc_sweep_misr.sv
// lc_sweep_misr: SIG_W-bit multiple-input signature register.
// Only used when LC_SWEEP_MISR_EN is defined.
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to zero (new sweep)
//   en         - fold din into the signature this cycle
//   din        - N_OUT-bit response, zero-extended into the fold
//   sig        - current signature
module lc_sweep_misr
    import lc_sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               N_OUT = 5,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [N_OUT-1:0] din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sig <= '0;
        else if (clr)
            sig <= '0;
        else if (en)
            sig <= SIG_W'(misr_step(32'(sig), 32'(din), 32'(POLY), SIG_W));
    end

endmodule

// File: rtl/lc_sweep_engine.sv
// lc_sweep_engine: exhaustive-stimulus engine for small combinational blocks.
// Drives codes vec_first..vec_last (inclusive, wrapping modulo 2^N_IN) on
// stim, waits SETTLE cycles per code, captures resp and offers each
// (stim, resp) pair on a valid/ready channel.
//
// Optional feature: define LC_SWEEP_MISR_EN to fold every accepted response
// into a SIG_W-bit MISR; otherwise signature is tied to zero.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - begin sweep (honoured in IDLE only)
//   abort                - return to IDLE from any busy state
//   vec_first, vec_last  - sweep range, latched at start
//   stim                 - vector driven into the logic under test
//   resp                 - response of the logic under test
//   out (master)         - out_valid/out_ready/out_stim/out_resp pair channel
//   busy                 - any state other than IDLE
//   done                 - one-cycle pulse at sweep completion
//   signature            - MISR value, held after done until the next start
module lc_sweep_engine
    import lc_sweep_pkg::*;
#(
    parameter int               N_IN   = 4,
    parameter int               N_OUT  = 5,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [N_IN-1:0]            vec_first,
    input  logic [N_IN-1:0]            vec_last,
    output logic [N_IN-1:0]            stim,
    input  logic [N_OUT-1:0]           resp,
    lc_sweep_engine_if.master          out,
    output logic                       busy,
    output logic                       done,
    output logic [SIG_W-1:0]           signature
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] last_q;
    logic [CW-1:0]   cnt_q;

    logic settle_last;
    logic is_last;
    logic load;
    logic capture;
    logic hs;
    logic adv;

    assign settle_last = (cnt_q == CW'(SETTLE - 1));
    assign is_last     = (stim == last_q);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY:   if (abort) state_d = IDLE;
                     else if (settle_last) state_d = CAPTURE;
            CAPTURE: if (abort) state_d = IDLE;
                     else if (out.out_ready) state_d = is_last ? DONE : APPLY;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs / datapath strobes ----------------
    // abort wins over a handshake landing in the same cycle, so an aborted
    // pair never reaches the signature or advances stim.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        load    = (state_q == IDLE) && start;
        capture = (state_q == APPLY) && settle_last && !abort;
        hs      = (state_q == CAPTURE) && out.out_ready && !abort;
        adv     = hs && !is_last;
    end

    // ---------------- stimulus counter and range latch ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim   <= '0;
            last_q <= '0;
        end else if (load) begin
            stim   <= vec_first;
            last_q <= vec_last;
        end else if (adv) begin
            stim   <= stim + N_IN'(1);   // wraps naturally at 2^N_IN
        end
    end

    // ---------------- settle counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (load || capture)
            cnt_q <= '0;
        else if (state_q == APPLY && !abort)
            cnt_q <= cnt_q + CW'(1);
    end

    // ---------------- output pair register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out.out_valid <= 1'b0;
            out.out_stim  <= '0;
            out.out_resp  <= '0;
        end else begin
            if (busy && abort)
                out.out_valid <= 1'b0;
            else if (capture)
                out.out_valid <= 1'b1;
            else if (hs)
                out.out_valid <= 1'b0;
            if (capture) begin
                out.out_stim <= stim;
                out.out_resp <= resp;
            end
        end
    end

    // ---------------- signature ----------------
`ifdef LC_SWEEP_MISR_EN
    lc_sweep_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .POLY  (POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .en    (hs),
        .din   (out.out_resp),
        .sig   (signature)
    );
`else
    assign signature = '0;
`endif

endmodule

// File: tb/tb_lc_sweep_engine.sv
// tb_lc_sweep_engine: directed, table-driven bench for lc_sweep_engine with
// N_IN=4, N_OUT=5, SETTLE=1. A lookup table plays the logic under test.
// Signature expectations collapse to zero when LC_SWEEP_MISR_EN is undefined.
module tb_lc_sweep_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 5;
    localparam int SIG_W = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [N_IN-1:0]   vec_first;
    logic [N_IN-1:0]   vec_last;
    logic [N_IN-1:0]   stim;
    logic [N_OUT-1:0]  resp;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  signature;

    logic [N_OUT-1:0]  lut [16];

    int nchk = 0;
    int errs = 0;

    lc_sweep_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT)) lif ();

    lc_sweep_engine #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .SETTLE (1),
        .SIG_W  (SIG_W),
        .POLY   (16'h1021)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .vec_first (vec_first),
        .vec_last  (vec_last),
        .stim      (stim),
        .resp      (resp),
        .out       (lif),
        .busy      (busy),
        .done      (done),
        .signature (signature)
    );

    assign resp = lut[stim];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  first;
        logic [3:0]  last;
        int          mode;      // 0: resp=stim, 1: resp=1F, 2: odd->01 even->02
        int          exp_n;
        int          stall_at;  // pair index to hold ready low for 5 cycles, -1 none
        logic        chk_sig;
        logic [15:0] exp_sig;
        int          exp_cyc;   // cycles from start edge to done
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] sigx(input logic [15:0] v);
`ifdef LC_SWEEP_MISR_EN
        return v;
`else
        return (v & 16'h0000);
`endif
    endfunction

    function automatic logic [15:0] misr_m(input logic [15:0] s, input logic [4:0] r);
        logic [15:0] n;
        n = {s[14:0], 1'b0} ^ {11'b0, r};
        if (s[15]) n = n ^ 16'h1021;
        return sigx(n);
    endfunction

    task automatic set_lut(input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                1:       lut[i] = 5'h1F;
                2:       lut[i] = (i % 2 == 1) ? 5'h01 : 5'h02;
                default: lut[i] = 5'(i);
            endcase
        end
    endtask

    task automatic do_sweep(input logic [3:0] first, input logic [3:0] last,
                            input int exp_n, input int stall_at,
                            input logic chk_sig, input logic [15:0] exp_sig,
                            output int done_cyc);
        int          npairs;
        int          ndone;
        int          cyc;
        logic [3:0]  exp_stim;
        logic [15:0] msig;
        logic        sig_pend;
        logic [4:0]  exp_r;
        vec_first = first;
        vec_last  = last;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cyc       = 1;
        chk("first_stim", 32'(stim), 32'(first));
        chk("busy_run", 32'(busy), 1);
        exp_stim = first;
        msig     = 16'h0;
        npairs   = 0;
        ndone    = 0;
        sig_pend = 1'b0;
        done_cyc = 0;
        while (ndone == 0 && cyc < 400) begin
            if (sig_pend) begin
                chk("sig_step", 32'(signature), 32'(msig));
                sig_pend = 1'b0;
            end
            if (done) begin
                ndone    = 1;
                done_cyc = cyc;
                chk("pair_count", npairs, exp_n);
                if (chk_sig) chk("sig_final", 32'(signature), 32'(sigx(exp_sig)));
            end else if (lif.out_valid) begin
                exp_r = lut[exp_stim];
                chk("out_stim", 32'(lif.out_stim), 32'(exp_stim));
                chk("out_resp", 32'(lif.out_resp), 32'(exp_r));
                if (npairs == stall_at) begin
                    lif.out_ready = 1'b0;
                    vec_first     = first + 4'd7;   // must be ignored mid-sweep
                    vec_last      = first;
                    start         = 1'b1;
                    repeat (5) begin
                        @(negedge clk);
                        cyc++;
                        start = 1'b0;
                        chk("stall_valid", 32'(lif.out_valid), 1);
                        chk("stall_stim", 32'(lif.out_stim), 32'(exp_stim));
                        chk("stall_resp", 32'(lif.out_resp), 32'(exp_r));
                        chk("stall_drive", 32'(stim), 32'(exp_stim));
                    end
                    vec_first     = first;
                    vec_last      = last;
                    lif.out_ready = 1'b1;
                end
                npairs++;
                msig     = misr_m(msig, exp_r);
                sig_pend = 1'b1;
                exp_stim = exp_stim + 4'd1;
            end
            @(negedge clk);
            cyc++;
        end
        if (ndone == 0) chk("done_timeout", 0, 1);
        chk("stim_hold_last", 32'(stim), 32'(last));
        @(negedge clk);
        chk("done_single", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("sig_held", 32'(signature), 32'(msig));
    endtask

    vec_t tbl [7];

    initial begin
        int          dc;
        int          nd;
        int          w;
        logic [15:0] sig_snap;

        tbl[0] = '{4'd0,  4'd15, 0, 16, -1, 1'b1, 16'h08F7, 33};
        tbl[1] = '{4'd3,  4'd3,  1, 1,  -1, 1'b1, 16'h001F, 3};
        tbl[2] = '{4'd14, 4'd1,  0, 4,  -1, 1'b1, 16'h004D, 9};
        tbl[3] = '{4'd5,  4'd6,  2, 2,  -1, 1'b1, 16'h0000, 5};
        tbl[4] = '{4'd15, 4'd0,  0, 2,  -1, 1'b1, 16'h001E, 5};
        tbl[5] = '{4'd0,  4'd2,  0, 3,   1, 1'b1, 16'h0000, 12};
        tbl[6] = '{4'd0,  4'd15, 1, 16, -1, 1'b0, 16'h0000, 33};

        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        vec_first     = '0;
        vec_last      = '0;
        lif.out_ready = 1'b1;
        set_lut(0);
        #1;
        chk("rst_stim", 32'(stim), 0);
        chk("rst_valid", 32'(lif.out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sig", 32'(signature), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 32'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            set_lut(tbl[i].mode);
            do_sweep(tbl[i].first, tbl[i].last, tbl[i].exp_n, tbl[i].stall_at,
                     tbl[i].chk_sig, tbl[i].exp_sig, dc);
            chk("done_cycle", dc, tbl[i].exp_cyc);
        end

        // abort during APPLY of the third vector
        set_lut(0);
        vec_first = 4'd4;
        vec_last  = 4'd10;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w     = 0;
        while (!(stim == 4'd6 && !lif.out_valid) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reach_apply", 32'(w < 20), 1);
        sig_snap = signature;
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(lif.out_valid), 0);
        chk("abort_sig", 32'(signature), 32'(sig_snap));
        nd = 0;
        repeat (4) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", nd, 0);

        // abort coinciding with a handshake: abort wins
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w     = 0;
        while (!lif.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("abort_hs_reach", 32'(lif.out_valid), 1);
        sig_snap = signature;
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_hs_valid", 32'(lif.out_valid), 0);
        chk("abort_hs_stim", 32'(stim), 4);
        chk("abort_hs_sig", 32'(signature), 32'(sig_snap));
        chk("abort_hs_done", 32'(done), 0);
        do_sweep(4'd4, 4'd5, 2, -1, 1'b1, 16'h000D, dc);
        chk("after_abort_cyc", dc, 5);

        // asynchronous reset mid-sweep
        vec_first = 4'd0;
        vec_last  = 4'd15;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stim", 32'(stim), 0);
        chk("mid_rst_valid", 32'(lif.out_valid), 0);
        chk("mid_rst_ostim", 32'(lif.out_stim), 0);
        chk("mid_rst_oresp", 32'(lif.out_resp), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_sig", 32'(signature), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd    = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("mid_rst_quiet", nd, 0);
        do_sweep(4'd2, 4'd2, 1, -1, 1'b1, 16'h0002, dc);
        chk("after_rst_cyc", dc, 3);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
